// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad column scanner with whole-matrix debounce and
//            one-pulse-per-press hex key output.
// Revision : 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_STB_W = $clog2(DEBOUNCE_SCANS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_STB_W-1:0] c_STB_MAX  = c_STB_W'(DEBOUNCE_SCANS - 1);
  // Legend indexed by {col, row}, entry 15 first.
  localparam logic [63:0] c_LEGEND = {4'hD, 4'hC, 4'hB, 4'hA,
                                      4'hE, 4'h9, 4'h6, 4'h3,
                                      4'hF, 4'h8, 4'h5, 4'h2,
                                      4'h0, 4'h7, 4'h4, 4'h1};

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PRESSED  = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_sync;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_col_idx;
  logic [3:0]         r_col;
  logic [11:0]        r_snap;
  logic [15:0]        r_prev_snap;
  logic [c_STB_W-1:0] r_stable_cnt;
  logic [3:0]         r_key_code;
  logic               r_key_valid;
  state_t             r_state;
  state_t             w_state_nxt;

  logic               w_last_dwell;
  logic               w_scan_end;
  logic [15:0]        w_snap_now;
  logic [c_STB_W-1:0] w_stable_nxt;
  logic               w_eval;
  logic               w_none;
  logic               w_single;
  logic               w_multi;
  logic [3:0]         w_code;
  logic               w_accept;

  assign w_last_dwell = (r_cnt == c_CNT_LAST);
  assign w_scan_end   = w_last_dwell && (r_col_idx == 2'd3);
  // Snapshot bits are stored pressed-high; column 3 is taken straight from
  // the synchronizer on the scan-end cycle.
  assign w_snap_now   = {~r_row_sync, r_snap};

  always_comb begin
    w_stable_nxt = '0;
    if (w_snap_now == r_prev_snap) begin
      w_stable_nxt = (r_stable_cnt == c_STB_MAX) ? r_stable_cnt
                                                 : r_stable_cnt + c_STB_W'(1);
    end
  end

  assign w_eval   = w_scan_end && (w_stable_nxt == c_STB_MAX);
  assign w_none   = (w_snap_now == 16'h0000);
  assign w_single = !w_none && ((w_snap_now & (w_snap_now - 16'd1)) == 16'h0000);
  assign w_multi  = !w_none && !w_single;

  always_comb begin
    w_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (w_snap_now[i]) w_code = c_LEGEND[i*4 +: 4];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (w_eval) begin
      unique case (r_state)
        S_RELEASED: begin
          if (w_single) begin
            w_state_nxt = S_PRESSED;
            w_accept    = 1'b1;
          end else if (w_multi) begin
            w_state_nxt = S_LOCKED;
          end
        end
        S_PRESSED: begin
          if (w_none)                                w_state_nxt = S_RELEASED;
          else if (w_multi || (w_code != r_key_code)) w_state_nxt = S_LOCKED;
        end
        S_LOCKED: begin
          if (w_none) w_state_nxt = S_RELEASED;
        end
        default: w_state_nxt = S_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta   <= 4'hF;
      r_row_sync   <= 4'hF;
      r_cnt        <= '0;
      r_col_idx    <= 2'd0;
      r_col        <= 4'b1110;
      r_snap       <= '0;
      r_prev_snap  <= '0;
      r_stable_cnt <= '0;
      r_key_code   <= 4'h0;
      r_key_valid  <= 1'b0;
      r_state      <= S_RELEASED;
    end else begin
      r_row_meta  <= row;
      r_row_sync  <= r_row_meta;
      r_key_valid <= w_accept;
      r_state     <= w_state_nxt;
      if (w_accept) r_key_code <= w_code;
      if (w_last_dwell) begin
        r_cnt     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= {r_col[2:0], r_col[3]};
        if (r_col_idx == 2'd0)      r_snap[3:0]  <= ~r_row_sync;
        else if (r_col_idx == 2'd1) r_snap[7:4]  <= ~r_row_sync;
        else if (r_col_idx == 2'd2) r_snap[11:8] <= ~r_row_sync;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_scan_end) begin
        r_prev_snap  <= w_snap_now;
        r_stable_cnt <= w_stable_nxt;
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = (r_state == S_PRESSED);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed bench for keypad_scanner with a matrix model and a
//            pulse scoreboard (expected code + expected scan number).
// Revision : 1.0
// ============================================================================
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;  // bit r*4+c
  int          vectors     = 0;
  int          miscompares = 0;
  int          scan_ctr    = 0;

  typedef struct {
    logic [3:0] code;
    int         scan;
  } exp_t;
  exp_t sb[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts scan starts and pops the scoreboard on each pulse.
  initial begin
    logic [3:0] prev_col;
    exp_t       e;
    prev_col = 4'b1110;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_col = 4'b1110;
      end else begin
        if (prev_col == 4'b0111 && col == 4'b1110) scan_ctr++;
        prev_col = col;
        if (key_valid !== 1'b0) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", {31'd0, key_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
            check("pulse_scan", scan_ctr, e.scan);
          end
        end
      end
    end
  end

  task automatic wait_scans(input int n);
    int target;
    int budget;
    target = scan_ctr + n;
    budget = n * 16 + 40;
    while (scan_ctr < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (scan_ctr < target) check("scan_timeout", scan_ctr, target);
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int scans);
    exp_t e;
    e.code = code;
    e.scan = scan_ctr + scans;
    sb.push_back(e);
  endtask

  initial begin
    logic [3:0] exp_col;
    rst_n   = 1'b0;
    pressed = 16'h0000;

    // 1) reset values and idle column sequence
    repeat (3) @(negedge clk);
    #1;
    check("rst_col",   {28'd0, col},      32'hE);
    check("rst_code",  {28'd0, key_code}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held",  {31'd0, key_held},  32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      exp_col = 4'b0001 << ((k / 4) % 4);
      exp_col = ~exp_col;
      check("idle_col", {28'd0, col}, {28'd0, exp_col});
    end
    wait_scans(8);
    check("idle_held", {31'd0, key_held}, 32'd0);
    check("idle_sb",   sb.size(), 0);

    // 2) single key (r1,c2) -> 6 at the 3rd scan end
    wait_scans(1);
    pressed[1*4+2] = 1'b1;
    expect_pulse(4'h6, 3);
    wait_scans(2);
    check("k6_not_yet", {31'd0, key_held}, 32'd0);
    wait_scans(1);
    check("k6_held", {31'd0, key_held}, 32'd1);
    check("k6_code", {28'd0, key_code}, 32'h6);
    check("k6_sb",   sb.size(), 0);
    wait_scans(2);
    check("k6_still_held", {31'd0, key_held}, 32'd1);
    pressed = 16'h0000;
    wait_scans(2);
    check("k6_rel_pending", {31'd0, key_held}, 32'd1);
    wait_scans(1);
    check("k6_released", {31'd0, key_held}, 32'd0);
    check("k6_code_kept", {28'd0, key_code}, 32'h6);

    // 3) one-scan glitch on (r3,c1) ignored, then a real hold -> F
    pressed[3*4+1] = 1'b1;
    wait_scans(1);
    pressed = 16'h0000;
    wait_scans(4);
    check("glitch_held", {31'd0, key_held}, 32'd0);
    check("glitch_code", {28'd0, key_code}, 32'h6);
    pressed[3*4+1] = 1'b1;
    expect_pulse(4'hF, 3);
    wait_scans(3);
    check("kF_held", {31'd0, key_held}, 32'd1);
    check("kF_sb",   sb.size(), 0);
    pressed = 16'h0000;
    wait_scans(4);

    // 4) two keys lock out, partial release stays locked, then (r0,c3) -> A
    pressed[0*4+0] = 1'b1;
    pressed[2*4+3] = 1'b1;
    wait_scans(4);
    check("multi_held", {31'd0, key_held}, 32'd0);
    check("multi_code", {28'd0, key_code}, 32'hF);
    pressed[0*4+0] = 1'b0;
    wait_scans(4);
    check("locked_held", {31'd0, key_held}, 32'd0);
    pressed = 16'h0000;
    wait_scans(4);
    pressed[0*4+3] = 1'b1;
    expect_pulse(4'hA, 3);
    wait_scans(3);
    check("kA_held", {31'd0, key_held}, 32'd1);
    check("kA_sb",   sb.size(), 0);
    pressed = 16'h0000;
    wait_scans(4);

    // 5) hold (r0,c0), then slide to (r0,c1) without release
    pressed[0*4+0] = 1'b1;
    expect_pulse(4'h1, 3);
    wait_scans(3);
    check("k1_held", {31'd0, key_held}, 32'd1);
    pressed = 16'h0000;
    pressed[0*4+1] = 1'b1;
    wait_scans(4);
    check("slide_held", {31'd0, key_held}, 32'd0);
    check("slide_code", {28'd0, key_code}, 32'h1);
    pressed = 16'h0000;
    wait_scans(4);
    check("slide_rel_held", {31'd0, key_held}, 32'd0);
    check("slide_sb", sb.size(), 0);

    // 6) async reset mid-dwell with key held, then re-acquire -> 9
    pressed[2*4+2] = 1'b1;
    expect_pulse(4'h9, 3);
    wait_scans(3);
    check("k9_held", {31'd0, key_held}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_col",   {28'd0, col},       32'hE);
    check("arst_held",  {31'd0, key_held},  32'd0);
    check("arst_valid", {31'd0, key_valid}, 32'd0);
    check("arst_code",  {28'd0, key_code},  32'h0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    expect_pulse(4'h9, 3);
    wait_scans(2);
    check("k9_re_not_yet", {31'd0, key_held}, 32'd0);
    wait_scans(1);
    check("k9_re_held", {31'd0, key_held}, 32'd1);
    check("k9_re_code", {28'd0, key_code}, 32'h9);
    pressed = 16'h0000;
    wait_scans(4);
    check("final_held", {31'd0, key_held}, 32'd0);
    check("final_sb",   sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
